regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (reg_wr / wr_reg / wr_data) between two write-back requesters: the ALU (req0) and the load/store unit (req1, variable latency).
- Fixed priority to ALU, with a starvation guard that forces a load grant after a bounded wait.
- Holds a 32-entry pending-write scoreboard. Issue logic uses it for RAW hazard detection and WAW issue stalls.
- Sits between the execute/memory stages and the register file.

Parameters:
- STARVE_MAX, 3, consecutive cycles req1 may wait while valid before it wins arbitration unconditionally (range 1..15).
- CNT_W, 4, width of the starvation counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  ALU write-back request
- req0_ready  out  1  ALU request accepted this cycle
- req0_rd  in  5  ALU destination register
- req0_data  in  32  ALU result
- req1_valid  in  1  LSU write-back request
- req1_ready  out  1  LSU request accepted this cycle
- req1_rd  in  5  LSU destination register
- req1_data  in  32  load data
- issue_valid  in  1  decode issuing an instruction that writes issue_rd
- issue_rd  in  5  destination of the issuing instruction
- issue_ready  out  1  issue allowed (no WAW conflict)
- rs1, rs2  in  5 each  source registers of the instruction in decode
- hazard1, hazard2  out  1 each  the source register has a pending write
- reg_wr  out  1  register-file write enable
- wr_reg  out  5  register-file write address
- wr_data  out  32  register-file write data

Behaviour:
- Reset is asynchronous and active-high (rst); clock is clk. On reset: reg_wr=0, wr_reg=0, wr_data=0, pending[31:0]=0, starve_cnt=0. A reset mid-transaction discards any accepted-but-uncommitted write.
- Force condition: force = (starve_cnt >= STARVE_MAX).
- Grant, combinational:
  - req1_ready = req1_valid & (force | ~req0_valid).
  - req0_ready = req0_valid & ~req1_ready.
  - At most one ready per cycle. Ready is low whenever the matching valid is low.
- Handshake:
  - A requester holds valid, rd and data stable until its ready is high.
  - Transfer happens at the rising edge where valid and ready are both 1.
- Write path, registered, latency 1:
  - Transfer at edge N puts wr_reg/wr_data = the granted rd/data during cycle N+1.
  - reg_wr = 1 during cycle N+1 only if the granted rd != 0.
  - With no transfer, reg_wr = 0 and wr_reg/wr_data hold their previous values.
  - A write to x0 is accepted (ready=1) and silently dropped.
- Starvation counter:
  - Increments (saturating at 2^CNT_W-1) each edge where req1_valid=1 and req1_ready=0.
  - Clears to 0 on a req1 transfer, or when req1_valid=0.
- Scoreboard:
  - issue_ready = (issue_rd == 0) | ~pending[issue_rd].
  - On edge with issue_valid & issue_ready & issue_rd != 0: pending[issue_rd] is set.
  - On edge with reg_wr=1: pending[wr_reg] is cleared. Clearing happens at the same edge the register file latches the data.
  - Set and clear on the same index in the same edge: set wins.
  - pending[0] is constant 0.
- Hazard outputs, combinational:
  - hazard1 = pending[rs1]; hazard2 = pending[rs2].
  - No bypass: a source register reads as hazard during the reg_wr cycle and is clear the following cycle.
- Simultaneous req0/req1 valid without force: req0 wins and req1 waits. In the STARVE_MAX-th waiting cycle, force=1 and req1 wins while req0 waits.

Decomposition:
- Shared package: REG_ADDR_W=5, XLEN=32, NUM_REGS=32, and a wb_req struct {valid, rd, data}.
- One natural sub-module, wb_scoreboard: pending vector, set/clear logic, issue_ready and hazard outputs.
- Arbitration, starvation counter and the output register stay in the top level.

Test Plan:
- Reset: assert rst mid-cycle with pending=0x0000_0F00 → outputs 0 immediately, pending=0, starve_cnt=0; first post-reset req0 (rd=5, data=0xDEADBEEF) → reg_wr=1, wr_reg=5, wr_data=0xDEADBEEF one cycle later.
- Contention: req0_valid and req1_valid held every cycle, STARVE_MAX=3 → grant sequence 0,0,0,1,0,0,0,1…; req1 is never starved longer than 3 cycles.
- x0 drop: req1 rd=0, data=0x1234 → req1_ready=1, reg_wr stays 0, pending unchanged.
- WAW stall: issue rd=7 accepted; second issue rd=7 → issue_ready=0 until the cycle after reg_wr=1 with wr_reg=7, then issue_ready=1.
- RAW: issue rd=10; rs1=10 → hazard1=1 through the reg_wr cycle for rd=10; hazard1=0 the next cycle; rs2=0 → hazard2=0 always.
- Same-edge set/clear: reg_wr commits rd=3 in the same edge as a new issue rd=3 (pending[3] was cleared by the commit path, issue_ready=1 via an idle reg) → pending[3]=1 after the edge.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and sizes for the register-file write-back arbiter.
//   REG_ADDR_W : register address width
//   XLEN       : register data width
//   NUM_REGS   : number of architectural registers (x0 hardwired to zero)
//   wb_req_t   : one write-back request {valid, rd, data}
package regfile_wb_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_REGS   = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at commit.
//   clk, rst                : clock, async active-high reset
//   issue_valid/issue_rd    : instruction in decode that will write issue_rd
//   issue_ready             : no write to issue_rd is outstanding (WAW guard)
//   rs1, rs2                : decode source registers
//   hazard1, hazard2        : the matching source has an outstanding write
//   clr_valid/clr_rd        : register-file commit this cycle
module regfile_wb_arbiter_wb_scoreboard
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  hazard1,
    output logic                  hazard2,
    input  logic                  clr_valid,
    input  logic [REG_ADDR_W-1:0] clr_rd
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic                set_en;

    // Lookups and next pending vector; set is applied after clear so it wins.
    always_comb begin
        issue_ready = (issue_rd == '0) | ~pending_q[issue_rd];
        hazard1     = pending_q[rs1];
        hazard2     = pending_q[rs2];
        set_en      = issue_valid & issue_ready & (issue_rd != '0);
        pending_d   = pending_q;
        if (clr_valid) begin
            pending_d[clr_rd] = 1'b0;
        end
        if (set_en) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU (req0) and LSU (req1).
// ALU has fixed priority; after STARVE_MAX waiting cycles the LSU wins.
//   clk, rst                         : clock, async active-high reset
//   req0_valid/ready/rd/data         : ALU write-back handshake
//   req1_valid/ready/rd/data         : LSU write-back handshake
//   issue_valid/issue_rd/issue_ready : decode WAW check against pending writes
//   rs1, rs2, hazard1, hazard2       : decode RAW check
//   reg_wr, wr_reg, wr_data          : registered register-file write port
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 3,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [REG_ADDR_W-1:0] req0_rd,
    input  logic [XLEN-1:0]       req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [REG_ADDR_W-1:0] req1_rd,
    input  logic [XLEN-1:0]       req1_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  hazard1,
    output logic                  hazard2,
    output logic                  reg_wr,
    output logic [REG_ADDR_W-1:0] wr_reg,
    output logic [XLEN-1:0]       wr_data
);

    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    logic [CNT_W-1:0] starve_cnt;
    logic             force_req1;
    wb_req_t          req0;
    wb_req_t          req1;
    wb_req_t          grant;

    // Grant: LSU wins when forced or when the ALU is idle.
    always_comb begin
        req0       = '{valid: req0_valid, rd: req0_rd, data: req0_data};
        req1       = '{valid: req1_valid, rd: req1_rd, data: req1_data};
        force_req1 = (starve_cnt >= CNT_W'(STARVE_MAX));
        req1_ready = req1.valid & (force_req1 | ~req0.valid);
        req0_ready = req0.valid & ~req1_ready;
        grant       = req1_ready ? req1 : req0;
        grant.valid = req0_ready | req1_ready;
    end

    // Consecutive cycles the LSU has been kept waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!req1_valid || req1_ready) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_SAT) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Write port: address/data follow every transfer; x0 writes are not enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_wr  <= 1'b0;
            wr_reg  <= '0;
            wr_data <= '0;
        end else begin
            reg_wr <= grant.valid & (grant.rd != '0);
            if (grant.valid) begin
                wr_reg  <= grant.rd;
                wr_data <= grant.data;
            end
        end
    end

    regfile_wb_arbiter_wb_scoreboard u_wb_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .hazard1     (hazard1),
        .hazard2     (hazard2),
        .clr_valid   (reg_wr),
        .clr_rd      (wr_reg)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

    localparam int unsigned STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [4:0]  req0_rd, req1_rd, issue_rd, rs1, rs2, wr_reg;
    logic [31:0] req0_data, req1_data, wr_data;
    logic        issue_valid, issue_ready, hazard1, hazard2, reg_wr;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd), .req1_data(req1_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rs1(rs1), .rs2(rs2), .hazard1(hazard1), .hazard2(hazard2),
        .reg_wr(reg_wr), .wr_reg(wr_reg), .wr_data(wr_data)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, want, $time);
        end
    endtask

    typedef struct {
        logic        r0v;  logic [4:0] r0rd; logic [31:0] r0d;
        logic        r1v;  logic [4:0] r1rd; logic [31:0] r1d;
        logic        iv;   logic [4:0] ird;  logic [4:0] s1; logic [4:0] s2;
        logic        e_r0; logic e_r1; logic e_ir; logic e_h1; logic e_h2;
        logic        e_wr; logic [4:0] e_wreg; logic [31:0] e_wdata;
    } vec_t;

    function automatic vec_t mk(
        input logic r0v, input logic [4:0] r0rd, input logic [31:0] r0d,
        input logic r1v, input logic [4:0] r1rd, input logic [31:0] r1d,
        input logic iv, input logic [4:0] ird, input logic [4:0] s1, input logic [4:0] s2,
        input logic e_r0, input logic e_r1, input logic e_ir, input logic e_h1, input logic e_h2,
        input logic e_wr, input logic [4:0] e_wreg, input logic [31:0] e_wdata);
        vec_t v;
        v.r0v = r0v; v.r0rd = r0rd; v.r0d = r0d;
        v.r1v = r1v; v.r1rd = r1rd; v.r1d = r1d;
        v.iv = iv; v.ird = ird; v.s1 = s1; v.s2 = s2;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_ir = e_ir; v.e_h1 = e_h1; v.e_h2 = e_h2;
        v.e_wr = e_wr; v.e_wreg = e_wreg; v.e_wdata = e_wdata;
        return v;
    endfunction

    task automatic drive(input logic r0v, input logic [4:0] r0rd, input logic [31:0] r0d,
                         input logic r1v, input logic [4:0] r1rd, input logic [31:0] r1d,
                         input logic iv, input logic [4:0] ird, input logic [4:0] s1, input logic [4:0] s2);
        req0_valid = r0v; req0_rd = r0rd; req0_data = r0d;
        req1_valid = r1v; req1_rd = r1rd; req1_data = r1d;
        issue_valid = iv; issue_rd = ird; rs1 = s1; rs2 = s2;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    vec_t tbl[21];

    // Reference model state for the random phase
    bit          pend[32];
    int unsigned r1_wait;
    int unsigned dut_wait;
    bit          m_wr;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    bit          a_v, b_v, g0, g1, m_ir;
    logic [4:0]  a_rd, b_rd;
    logic [31:0] a_d, b_d;

    initial begin
        idle();

        // Stimulus table: outputs expected at mid-cycle after inputs are applied.
        //        r0v rd    data          r1v rd    data      iv ird  rs1  rs2   r0 r1 ir h1 h2 wr wreg  wdata
        tbl[0]  = mk(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,    0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0, 0, 0, 5'd0, 32'h0);
        tbl[1]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 1, 5'd5, 32'hDEADBEEF);
        tbl[2]  = mk(1, 5'd1, 32'h11,       1, 5'd2, 32'h22,   0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0, 0, 0, 5'd5, 32'hDEADBEEF);
        tbl[3]  = mk(1, 5'd1, 32'h11,       1, 5'd2, 32'h22,   0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0, 0, 1, 5'd1, 32'h11);
        tbl[4]  = mk(1, 5'd1, 32'h11,       1, 5'd2, 32'h22,   0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0, 0, 1, 5'd1, 32'h11);
        tbl[5]  = mk(1, 5'd1, 32'h11,       1, 5'd2, 32'h22,   0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0, 1, 5'd1, 32'h11);
        tbl[6]  = mk(1, 5'd1, 32'h11,       1, 5'd2, 32'h22,   0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0, 0, 1, 5'd2, 32'h22);
        tbl[7]  = mk(1, 5'd1, 32'h11,       1, 5'd2, 32'h22,   0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0, 0, 1, 5'd1, 32'h11);
        tbl[8]  = mk(1, 5'd1, 32'h11,       1, 5'd2, 32'h22,   0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0, 0, 1, 5'd1, 32'h11);
        tbl[9]  = mk(1, 5'd1, 32'h11,       1, 5'd2, 32'h22,   0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0, 1, 5'd1, 32'h11);
        tbl[10] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 1, 5'd2, 32'h22);
        tbl[11] = mk(0, 5'd0, 32'h0,        1, 5'd0, 32'h1234, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0, 0, 5'd2, 32'h22);
        tbl[12] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 5'd0, 32'h1234);
        tbl[13] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1, 5'd7, 5'd7, 5'd0, 0, 0, 1, 0, 0, 0, 5'd0, 32'h1234);
        tbl[14] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1, 5'd7, 5'd7, 5'd0, 0, 0, 0, 1, 0, 0, 5'd0, 32'h1234);
        tbl[15] = mk(1, 5'd7, 32'h77,       0, 5'd0, 32'h0,    1, 5'd7, 5'd7, 5'd0, 1, 0, 0, 1, 0, 0, 5'd0, 32'h1234);
        tbl[16] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1, 5'd7, 5'd7, 5'd0, 0, 0, 0, 1, 0, 1, 5'd7, 32'h77);
        tbl[17] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 5'd7, 5'd7, 5'd0, 0, 0, 1, 0, 0, 0, 5'd7, 32'h77);
        tbl[18] = mk(1, 5'd3, 32'h33,       0, 5'd0, 32'h0,    0, 5'd0, 5'd3, 5'd0, 1, 0, 1, 0, 0, 0, 5'd7, 32'h77);
        tbl[19] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1, 5'd3, 5'd3, 5'd0, 0, 0, 1, 0, 0, 1, 5'd3, 32'h33);
        tbl[20] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 5'd3, 5'd3, 5'd3, 0, 0, 0, 1, 1, 0, 5'd3, 32'h33);

        // Initial reset
        repeat (2) @(negedge clk);
        check("reset reg_wr", 32'(reg_wr), 32'd0);
        check("reset wr_data", wr_data, 32'd0);
        rst = 1'b0;

        // Build pending = 0x0F00, starve count = 3, and a commit in flight, then reset mid-cycle.
        @(negedge clk); drive(0, 5'd0, 32'h0,       0, 5'd0, 32'h0, 1, 5'd8,  5'd0, 5'd0);
        @(negedge clk); drive(1, 5'd0, 32'h0,       1, 5'd0, 32'h0, 1, 5'd9,  5'd0, 5'd0);
        @(negedge clk); drive(1, 5'd0, 32'h0,       1, 5'd0, 32'h0, 1, 5'd10, 5'd0, 5'd0);
        @(negedge clk); drive(1, 5'd12, 32'hCAFE,   1, 5'd0, 32'h0, 1, 5'd11, 5'd0, 5'd0);
        @(negedge clk); idle(); rs1 = 5'd9;
        #1;
        check("pre-rst reg_wr", 32'(reg_wr), 32'd1);
        check("pre-rst wr_reg", 32'(wr_reg), 32'd12);
        check("pre-rst hazard rs1=9", 32'(hazard1), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid-rst reg_wr", 32'(reg_wr), 32'd0);
        check("mid-rst wr_reg", 32'(wr_reg), 32'd0);
        check("mid-rst wr_data", wr_data, 32'd0);
        for (int r = 8; r < 12; r++) begin
            rs1 = 5'(r); issue_rd = 5'(r);
            #0.1;
            check($sformatf("mid-rst hazard1 x%0d", r), 32'(hazard1), 32'd0);
            check($sformatf("mid-rst issue_ready x%0d", r), 32'(issue_ready), 32'd1);
        end
        @(negedge clk); idle(); rst = 1'b0;

        // Starve count cleared by reset: ALU wins three times before the LSU is forced.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(1, 5'd0, 32'h0, 1, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
            #1;
            check($sformatf("post-rst contend%0d req0_ready", c), 32'(req0_ready), (c < 3) ? 32'd1 : 32'd0);
            check($sformatf("post-rst contend%0d req1_ready", c), 32'(req1_ready), (c < 3) ? 32'd0 : 32'd1);
        end
        @(negedge clk); idle();

        // Table
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            drive(tbl[i].r0v, tbl[i].r0rd, tbl[i].r0d, tbl[i].r1v, tbl[i].r1rd, tbl[i].r1d,
                  tbl[i].iv, tbl[i].ird, tbl[i].s1, tbl[i].s2);
            #1;
            check($sformatf("row%0d req0_ready", i), 32'(req0_ready), 32'(tbl[i].e_r0));
            check($sformatf("row%0d req1_ready", i), 32'(req1_ready), 32'(tbl[i].e_r1));
            check($sformatf("row%0d issue_ready", i), 32'(issue_ready), 32'(tbl[i].e_ir));
            check($sformatf("row%0d hazard1", i), 32'(hazard1), 32'(tbl[i].e_h1));
            check($sformatf("row%0d hazard2", i), 32'(hazard2), 32'(tbl[i].e_h2));
            check($sformatf("row%0d reg_wr", i), 32'(reg_wr), 32'(tbl[i].e_wr));
            check($sformatf("row%0d wr_reg", i), 32'(wr_reg), 32'(tbl[i].e_wreg));
            check($sformatf("row%0d wr_data", i), wr_data, tbl[i].e_wdata);
        end

        // Re-reset, then randomized traffic against the reference model.
        @(negedge clk); idle(); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        foreach (pend[k]) pend[k] = 1'b0;
        r1_wait = 0; dut_wait = 0;
        m_wr = 1'b0; m_reg = 5'd0; m_data = 32'd0;
        a_v = 1'b0; b_v = 1'b0; a_rd = 5'd0; b_rd = 5'd0; a_d = 32'd0; b_d = 32'd0;

        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (!a_v && $urandom_range(0, 99) < 60) begin
                a_v = 1'b1; a_rd = 5'($urandom_range(0, 7)); a_d = $urandom;
            end
            if (!b_v && $urandom_range(0, 99) < 50) begin
                b_v = 1'b1; b_rd = 5'($urandom_range(0, 7)); b_d = $urandom;
            end
            drive(a_v, a_rd, a_d, b_v, b_rd, b_d, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            #1;
            // LSU wins once it has waited STARVE_MAX cycles or the ALU is idle.
            g1   = b_v && (r1_wait >= STARVE_MAX || !a_v);
            g0   = a_v && !g1;
            m_ir = (issue_rd == 5'd0) || !pend[issue_rd];
            check("rnd req0_ready", 32'(req0_ready), 32'(g0));
            check("rnd req1_ready", 32'(req1_ready), 32'(g1));
            check("rnd issue_ready", 32'(issue_ready), 32'(m_ir));
            check("rnd hazard1", 32'(hazard1), 32'(pend[rs1]));
            check("rnd hazard2", 32'(hazard2), 32'(pend[rs2]));
            check("rnd reg_wr", 32'(reg_wr), 32'(m_wr));
            check("rnd wr_reg", 32'(wr_reg), 32'(m_reg));
            check("rnd wr_data", wr_data, m_data);
            if (req1_valid && !req1_ready) dut_wait++; else dut_wait = 0;
            check("rnd starve bound", 32'(dut_wait <= STARVE_MAX), 32'd1);

            // Advance the model across the coming edge.
            if (m_wr) pend[m_reg] = 1'b0;
            if (issue_valid && m_ir && issue_rd != 5'd0) pend[issue_rd] = 1'b1;
            if (g1) begin
                m_wr = (b_rd != 5'd0); m_reg = b_rd; m_data = b_d;
            end else if (g0) begin
                m_wr = (a_rd != 5'd0); m_reg = a_rd; m_data = a_d;
            end else begin
                m_wr = 1'b0;
            end
            r1_wait = (b_v && !g1) ? r1_wait + 1 : 0;
            if (g0) a_v = 1'b0;
            if (g1) b_v = 1'b0;
        end

        @(negedge clk); idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
